// File: rtl/helix_thought_framer.sv
// ---------------------------------------------------------------------------
// helix_thought_framer
//   Takes the reactor's thought stream, buffers it in a small first-word-
//   fall-through FIFO and re-emits it as frames of FRAME_LEN beats with a
//   last flag and a frame id. Upstream is held off only when the FIFO is full
//   and the egress side is stalled. A flush pulse closes the current frame
//   early (end of sequence).
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous reset, active-high
//   thought_valid  upstream beat valid
//   thought_ready  upstream beat accepted when valid & ready
//   thought_data   upstream beat data
//   flush          close the current frame (pulse)
//   frm_valid      egress beat valid
//   frm_ready      egress backpressure
//   frm_data       egress beat data
//   frm_last       final beat of a frame
//   frm_id         id of the frame this beat belongs to (wraps)
//   level          FIFO occupancy, 0..DEPTH
//   frames_done    frames fully emitted (wraps at 2**16)
// ---------------------------------------------------------------------------
`ifndef HELIX_THOUGHT_W
`define HELIX_THOUGHT_W 32
`endif

module helix_thought_framer #(
    parameter int THOUGHT_W = `HELIX_THOUGHT_W,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int FID_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     thought_valid,
    output logic                     thought_ready,
    input  logic [THOUGHT_W-1:0]     thought_data,
    input  logic                     flush,
    output logic                     frm_valid,
    input  logic                     frm_ready,
    output logic [THOUGHT_W-1:0]     frm_data,
    output logic                     frm_last,
    output logic [FID_W-1:0]         frm_id,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              frames_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
    localparam logic [7:0]    LAST_IDX   = 8'(FRAME_LEN - 1);

    logic [THOUGHT_W-1:0] mem_data_q [DEPTH];
    logic                 mem_last_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [FID_W-1:0]     frm_id_q, frm_id_d;
    logic [15:0]          frames_done_q, frames_done_d;

    logic wr_en;
    logic rd_en;
    logic last_in;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    // when egress is draining. Held low while reset is asserted.
    assign thought_ready = ~rst & ((level_q != DEPTH_L) | frm_ready);
    assign frm_valid     = (level_q != '0);

    assign wr_en = thought_valid & thought_ready;
    assign rd_en = frm_valid & frm_ready;

    assign last_in = (beat_cnt_q == LAST_IDX) | flush | flush_pend_q;

    // FWFT: the head entry is read straight out of registered storage.
    assign frm_data    = mem_data_q[rd_ptr_q];
    assign frm_last    = mem_last_q[rd_ptr_q];
    assign frm_id      = frm_id_q;
    assign level       = level_q;
    assign frames_done = frames_done_q;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        beat_cnt_d    = beat_cnt_q;
        flush_pend_d  = flush_pend_q;
        frm_id_d      = frm_id_q;
        frames_done_d = frames_done_q;

        if (wr_en) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            beat_cnt_d   = last_in ? 8'd0 : beat_cnt_q + 8'd1;
            flush_pend_d = 1'b0;
        end else if (flush) begin
            // Remember the close request; the next beat written ends the frame.
            flush_pend_d = 1'b1;
        end

        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (frm_last) begin
                frm_id_d      = frm_id_q + 1'b1;
                frames_done_d = frames_done_q + 16'd1;
            end
        end

        if (wr_en && !rd_en) begin
            level_d = level_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            beat_cnt_q    <= '0;
            flush_pend_q  <= 1'b0;
            frm_id_q      <= '0;
            frames_done_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            beat_cnt_q    <= beat_cnt_d;
            flush_pend_q  <= flush_pend_d;
            frm_id_q      <= frm_id_d;
            frames_done_q <= frames_done_d;
        end
    end

    // Storage is cleared on reset so frm_data/frm_last read as zero afterwards.
    // Only a real write touches it, so X on an idle data bus never lands here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            mem_data_q[wr_ptr_q] <= thought_data;
            mem_last_q[wr_ptr_q] <= last_in;
        end
    end

endmodule
